// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin scheduler sharing one pipelined 16x16 multiplier.
// Ports: clk/rst (async low); en; req_valid/ready/op1/op2 in; mul_op1/2, mul_res;
//        rsp_valid/ack/data per requester; busy; grant_id (last issued ID).
module mul_share_arb #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2,
  parameter int IDW     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*16-1:0] req_op1,
  input  logic [NREQ*16-1:0] req_op2,
  output logic [15:0]        mul_op1,
  output logic [15:0]        mul_op2,
  input  logic [31:0]        mul_res,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ack,
  output logic [NREQ*32-1:0] rsp_data,
  output logic               busy,
  output logic [IDW-1:0]     grant_id
);

  logic [NREQ-1:0]    pending;
  logic [NREQ-1:0]    elig;
  logic [NREQ-1:0]    sel;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     sel_id;
  logic [IDW-1:0]     nxt_ptr;
  logic               sel_v;
  logic               xfer;
  logic [MUL_LAT-1:0] pv;
  logic [IDW-1:0]     pid [MUL_LAT];
  logic               done;
  logic [IDW-1:0]     done_id;

  assign elig = req_valid & ~pending & {NREQ{en}};

  always_comb begin
    int idx;
    sel_v  = 1'b0;
    sel_id = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!sel_v && elig[idx]) begin
        sel_v  = 1'b1;
        sel_id = IDW'(idx);
      end
    end
    sel = sel_v ? (NREQ'(1) << sel_id) : '0;
  end

  // Gate with reset so nothing is offered while reset is held.
  assign req_ready = sel & {NREQ{rst}};
  assign xfer      = |(req_valid & req_ready);
  assign nxt_ptr   = (sel_id == IDW'(NREQ - 1)) ? '0 : sel_id + 1'b1;
  assign done      = pv[MUL_LAT-1];
  assign done_id   = pid[MUL_LAT-1];
  assign busy      = |pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      mul_op1  <= '0;
      mul_op2  <= '0;
    end else if (xfer) begin
      rr_ptr   <= nxt_ptr;
      grant_id <= sel_id;
      mul_op1  <= req_op1[{sel_id, 4'd0} +: 16];
      mul_op2  <= req_op2[{sel_id, 4'd0} +: 16];
    end
  end

  // Valid+ID shadow of the multiplier pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0;
      for (int k = 0; k < MUL_LAT; k++) pid[k] <= '0;
    end else begin
      pv[0]  <= xfer;
      pid[0] <= sel_id;
      for (int k = 1; k < MUL_LAT; k++) begin
        pv[k]  <= pv[k-1];
        pid[k] <= pid[k-1];
      end
    end
  end

  // Issue and ack never hit the same ID on one edge: issue needs !pending,
  // ack needs rsp_valid, which implies pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending   <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && rsp_ack[i]) begin
          rsp_valid[i] <= 1'b0;
          pending[i]   <= 1'b0;
        end
        if (done && done_id == IDW'(i)) begin
          rsp_valid[i]         <= 1'b1;
          rsp_data[32*i +: 32] <= mul_res;
        end
        if (xfer && sel[i]) pending[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: randomized + directed bench for mul_share_arb
// against a transaction-level reference model with a latency-L multiplier.
module tb_mul_share_arb;

  localparam int N   = 4;
  localparam int L   = 2;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en;
  logic [N-1:0]     vld;
  logic [N-1:0]     ack;
  logic [N*16-1:0]  o1;
  logic [N*16-1:0]  o2;
  logic [N-1:0]     req_ready;
  logic [15:0]      mul_op1;
  logic [15:0]      mul_op2;
  logic [31:0]      mul_res;
  logic [N-1:0]     rsp_valid;
  logic [N*32-1:0]  rsp_data;
  logic             busy;
  logic [IDW-1:0]   grant_id;

  mul_share_arb #(.NREQ(N), .MUL_LAT(L), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(vld), .req_ready(req_ready),
    .req_op1(o1), .req_op2(o2),
    .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_res(mul_res),
    .rsp_valid(rsp_valid), .rsp_ack(ack), .rsp_data(rsp_data),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Shared multiplier: product of the current operands, L-1 registers later.
  logic [31:0] mdly [L-1];
  always @(posedge clk) begin
    mdly[0] <= 32'(mul_op1) * 32'(mul_op2);
    for (int k = 1; k < L - 1; k++) mdly[k] <= mdly[k-1];
  end
  assign mul_res = mdly[L-2];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] prod;
  } fl_t;

  fl_t         fl[$];
  logic [N-1:0] m_pend;
  logic [N-1:0] m_sv;
  logic [31:0]  m_sd [N];
  int           m_p;
  int           m_gid;
  logic [15:0]  m_o1;
  logic [15:0]  m_o2;
  int           cyc;
  logic [N-1:0] er;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tot_cnt++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic m_reset();
    fl.delete();
    m_pend = '0;
    m_sv   = '0;
    for (int i = 0; i < N; i++) m_sd[i] = '0;
    m_p   = 0;
    m_gid = 0;
    m_o1  = '0;
    m_o2  = '0;
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_p + k) % N;
        if (r == '0 && vld[i] && !m_pend[i]) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic m_edge(input logic [N-1:0] gr);
    for (int i = 0; i < N; i++)
      if (m_sv[i] && ack[i]) begin
        m_sv[i]   = 1'b0;
        m_pend[i] = 1'b0;
      end
    cyc++;
    for (int j = fl.size() - 1; j >= 0; j--)
      if (fl[j].due == cyc) begin
        m_sv[fl[j].id] = 1'b1;
        m_sd[fl[j].id] = fl[j].prod;
        fl.delete(j);
      end
    for (int i = 0; i < N; i++)
      if (gr[i]) begin
        fl_t e;
        m_pend[i] = 1'b1;
        m_p   = (i + 1) % N;
        m_gid = i;
        m_o1  = o1[16*i +: 16];
        m_o2  = o2[16*i +: 16];
        e.due  = cyc + L;
        e.id   = i;
        e.prod = 32'(m_o1) * 32'(m_o2);
        fl.push_back(e);
      end
  endtask

  // Entered at posedge+1 with inputs already applied; leaves at posedge+1.
  task automatic step();
    #1;
    er = exp_ready();
    chk("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    m_edge(er);
    #1;
    chk("mul_op1", 64'(mul_op1), 64'(m_o1));
    chk("mul_op2", 64'(mul_op2), 64'(m_o2));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_sv));
    chk("busy", 64'(busy), 64'(|m_pend));
    for (int i = 0; i < N; i++)
      chk($sformatf("slot%0d", i), 64'(rsp_data[32*i +: 32]), 64'(m_sd[i]));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_op1"}, 64'(mul_op1), 64'd0);
    chk({tag, "_op2"}, 64'(mul_op2), 64'd0);
    chk({tag, "_rv"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rd"}, 64'(rsp_data[63:0] | rsp_data[127:64]), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_gid"}, 64'(grant_id), 64'd0);
  endtask

  // Async pulse placed between edges while requests are still asserted.
  task automatic pulse_rst();
    #1 rst = 1'b0;
    #1 check_zero("arst");
    m_reset();
    vld = '0;
    ack = '0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    m_edge('0);
    #1;
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 16'hFFFF;
      1:       return 16'(($urandom_range(0, 3)));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rnd_inputs();
    en  = ($urandom_range(0, 9) != 0);
    vld = N'($urandom);
    ack = N'($urandom);
    for (int i = 0; i < N; i++) begin
      o1[16*i +: 16] = rnd_op();
      o2[16*i +: 16] = rnd_op();
    end
  endtask

  initial begin
    en  = 1'b1;
    vld = '0;
    ack = '0;
    o1  = '0;
    o2  = '0;
    cyc = 0;
    m_reset();
    #1 check_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    m_edge('0);
    #1;

    // Single request 3 x 5 on requester 0.
    vld = 4'b0001;
    o1[15:0] = 16'h0003;
    o2[15:0] = 16'h0005;
    #1 chk("s1_ready", 64'(req_ready), 64'h1);
    step();
    chk("s1_op1", 64'(mul_op1), 64'h3);
    chk("s1_op2", 64'(mul_op2), 64'h5);
    vld = '0;
    step();
    chk("s1_rv_early", 64'(rsp_valid), 64'h0);
    step();
    chk("s1_rv", 64'(rsp_valid), 64'h1);
    chk("s1_slot0", 64'(rsp_data[31:0]), 64'h0000000F);
    repeat (3) step();
    chk("s1_hold", 64'(rsp_valid), 64'h1);
    chk("s1_busy", 64'(busy), 64'h1);
    ack = 4'b0001;
    step();
    ack = '0;
    chk("s1_busy_off", 64'(busy), 64'h0);
    chk("s1_rv_off", 64'(rsp_valid), 64'h0);

    // Full round robin with immediate acks.
    pulse_rst();
    en  = 1'b1;
    vld = '1;
    ack = '1;
    o1  = {16'hFFFF, 16'h0100, 16'h0012, 16'h0007};
    o2  = {16'hFFFF, 16'h0200, 16'h0034, 16'h0009};
    for (int i = 0; i < N; i++) begin
      step();
      chk("rr_gid", 64'(grant_id), 64'(i));
    end
    step();
    chk("rr_wrap", 64'(grant_id), 64'h0);
    step();
    chk("rr_slot3", 64'(rsp_data[127:96]), 64'hFFFE0001);
    chk("rr_rv3", 64'(rsp_valid[3]), 64'h1);
    repeat (8) step();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      rnd_inputs();
      step();
    end

    // Reset with work in flight, then first grant must go to requester 0.
    en  = 1'b1;
    vld = '1;
    ack = '0;
    repeat (3) step();
    chk("pre_rst_busy", 64'(busy), 64'h1);
    pulse_rst();
    repeat (4) step();
    chk("post_rst_rv", 64'(rsp_valid), 64'h0);
    vld = '1;
    #1 chk("post_rst_ready", 64'(req_ready), 64'h1);
    step();
    chk("post_rst_gid", 64'(grant_id), 64'h0);

    for (int n = 0; n < 500; n++) begin
      rnd_inputs();
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Round-robin arbiter/scheduler that shares one pipelined 16x16 multiplier datapath between NREQ requesters.
- Accepts operand pairs over valid/ready handshakes and drives the shared multiplier operand registers.
- Tracks in-flight operations by requester ID and returns each 32-bit product to a per-requester result slot held until acknowledged.
- Sits at chip level between the requesting sub-blocks and the shared multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 2, multiplier latency in cycles from mul_op1/mul_op2 change to valid mul_res (1..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  arbitration enable; 0 blocks new grants, in-flight ops still complete.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester grant/accept; one-hot or zero.
- req_op1  in  NREQ*16  packed operand A; requester i uses bits [16i+15:16i].
- req_op2  in  NREQ*16  packed operand B; same packing as req_op1.
- mul_op1  out  16  registered operand A to the shared multiplier.
- mul_op2  out  16  registered operand B to the shared multiplier.
- mul_res  in  32  multiplier product.
- rsp_valid  out  NREQ  per-requester result valid.
- rsp_ack  in  NREQ  per-requester result acknowledge.
- rsp_data  out  NREQ*32  packed per-requester result slots.
- busy  out  1  high when any op is in flight or any rsp_valid is high.
- grant_id  out  IDW  ID of the last issued requester.

Behaviour:
- Reset (rst=0, asynchronous) clears to 0: req_ready, mul_op1, mul_op2, rsp_valid, rsp_data, busy, grant_id, the RR pointer, the pending bits and the in-flight pipeline. Reset mid-operation discards all in-flight and unacknowledged results.
- pending[i] is set on issue to requester i and cleared on the edge where rsp_valid[i] and rsp_ack[i] are both high. Each requester has at most one outstanding op.
- Eligibility: requester i is eligible when req_valid[i], !pending[i] and en are all true.
- Arbitration is combinational. req_ready[i]=1 for the first eligible requester found scanning from RR pointer p upward, modulo NREQ. At most one bit is high. No eligible requester gives all zeros.
- Transfer occurs on the edge where req_valid[i] and req_ready[i] are both high. On that edge:
  - mul_op1/mul_op2 load requester i's operands;
  - grant_id is set to i;
  - p is set to (i+1) mod NREQ;
  - pending[i] is set to 1.
- mul_op registers hold their value between issues.
- Maximum throughput is one issue per cycle across different requesters.
- In-flight tracking uses a valid+ID shift pipeline of depth MUL_LAT. An op issued at edge t has mul_res sampled at edge t+MUL_LAT. On that edge, rsp_data slot[id] loads mul_res and rsp_valid[id] is set.
- rsp_valid[i] and rsp_data slot i hold until rsp_ack[i]. rsp_ack with no rsp_valid is ignored.
- No result collisions: a slot cannot be refilled before it is acknowledged, because pending blocks reissue.
- Ack and re-request by the same requester in the same cycle: the ack clears pending at that edge, so the earliest new grant is the following cycle.
- en deassertion takes effect combinationally on req_ready. The in-flight pipeline is unaffected.
- busy = |pending. This covers in-flight ops and unacknowledged results.
- Widths: products are unsigned 32-bit; no truncation.

Test Plan:
- Reset, then single request: req0 op1=0x0003, op2=0x0005 -> req_ready[0] same cycle; mul_op=3,5 next cycle; rsp_valid[0]=1 with slot0=0x0000000F 2 edges after issue; held until ack; busy drops after ack.
- All four requesting continuously, each acking immediately -> grants in order 0,1,2,3 one per cycle; after all acks, next round starts at 0; each slot holds its own correct product (e.g. 0xFFFF*0xFFFF=0xFFFE0001 in slot3).
- Requester 1 holds its result without ack while re-requesting -> req_ready[1] stays 0 and others are still served; ack at cycle N -> req_ready[1] earliest at N+1.
- en=0 with 2 ops in flight -> no new req_ready; both results still arrive at the correct slots after MUL_LAT.
- Async rst pulse asserted between edges with 3 ops in flight -> all outputs 0 immediately; no rsp_valid after release; first grant after release goes to requester 0.
- MUL_LAT=4 build, back-to-back issues to req2 then req0 -> results appear in slot2 then slot0, exactly 4 edges after each issue.
